// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } mem_state_t;

  localparam int unsigned REG_IDX_W = 4;
  localparam logic [REG_IDX_W-1:0] REG_PC = 4'd15;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline-side signals seen by the hazard controller; the pipeline drives
// the master side, the controller sits on the slave side.
interface pipeline_hazard_ctrl_if
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
);
  logic [REG_IDX_W-1:0] id_src1;
  logic [REG_IDX_W-1:0] id_src2;
  logic                 id_two_src;
  logic                 id_uses_status;
  logic                 exe_wb_en;
  logic [REG_IDX_W-1:0] exe_dest;
  logic                 exe_mem_r_en;
  logic                 exe_s;
  logic                 mem_wb_en;
  logic [REG_IDX_W-1:0] mem_dest;
  logic                 mem_access;
  logic                 sram_ready;
  logic                 exe_branch_taken;
  logic                 freeze_front;
  logic                 freeze_all;
  logic                 flush_if_id;
  logic                 flush_id_exe;
  logic                 sram_start;
  logic                 mem_timeout_err;
  logic [CNT_W-1:0]     stall_cycles;
  logic [CNT_W-1:0]     bubble_count;

  modport master (
    output id_src1, id_src2, id_two_src, id_uses_status,
    output exe_wb_en, exe_dest, exe_mem_r_en, exe_s,
    output mem_wb_en, mem_dest, mem_access, sram_ready, exe_branch_taken,
    input  freeze_front, freeze_all, flush_if_id, flush_id_exe,
    input  sram_start, mem_timeout_err, stall_cycles, bubble_count
  );

  modport slave (
    input  id_src1, id_src2, id_two_src, id_uses_status,
    input  exe_wb_en, exe_dest, exe_mem_r_en, exe_s,
    input  mem_wb_en, mem_dest, mem_access, sram_ready, exe_branch_taken,
    output freeze_front, freeze_all, flush_if_id, flush_id_exe,
    output sram_start, mem_timeout_err, stall_cycles, bubble_count
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_hazard_unit.sv
// Combinational RAW / status hazard detection for the instruction in ID.
module hazard_unit
  import pipe_ctrl_pkg::*;
#(
  parameter bit FWD_EN = 1'b1
) (
  input  logic [REG_IDX_W-1:0] id_src1_i,
  input  logic [REG_IDX_W-1:0] id_src2_i,
  input  logic                 id_two_src_i,
  input  logic                 id_uses_status_i,
  input  logic                 exe_wb_en_i,
  input  logic [REG_IDX_W-1:0] exe_dest_i,
  input  logic                 exe_mem_r_en_i,
  input  logic                 exe_s_i,
  input  logic                 mem_wb_en_i,
  input  logic [REG_IDX_W-1:0] mem_dest_i,
  output logic                 hazard_o
);

  logic exe_hit;
  logic mem_hit;
  logic exe_term;
  logic mem_term;

  // With forwarding only a load in EXE cannot be bypassed; MEM is always forwardable.
  always_comb begin
    exe_hit  = (exe_dest_i == id_src1_i) || (id_two_src_i && (exe_dest_i == id_src2_i));
    mem_hit  = (mem_dest_i == id_src1_i) || (id_two_src_i && (mem_dest_i == id_src2_i));
    exe_term = exe_wb_en_i & exe_hit & (exe_mem_r_en_i | ~FWD_EN);
    mem_term = mem_wb_en_i & mem_hit & ~FWD_EN;
    hazard_o = exe_term | mem_term | (id_uses_status_i & exe_s_i);
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer: SRAM access FSM, output priority and saturating perf counters.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter bit FWD_EN      = 1'b1,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  pipeline_hazard_ctrl_if.slave  bus
);

  localparam logic [3:0] WAIT_LAST = 4'(MEM_TIMEOUT - 1);

  mem_state_t       state_q, state_d;
  logic [3:0]       wait_cnt_q, wait_cnt_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] bubble_q, bubble_d;

  logic hazard;
  logic mem_freeze;
  logic req_pulse;
  logic freeze_front;
  logic freeze_all;
  logic flush_if_id;
  logic flush_id_exe;
  logic sram_start;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  hazard_unit #(.FWD_EN(FWD_EN)) u_hazard (
    .id_src1_i        (bus.id_src1),
    .id_src2_i        (bus.id_src2),
    .id_two_src_i     (bus.id_two_src),
    .id_uses_status_i (bus.id_uses_status),
    .exe_wb_en_i      (bus.exe_wb_en),
    .exe_dest_i       (bus.exe_dest),
    .exe_mem_r_en_i   (bus.exe_mem_r_en),
    .exe_s_i          (bus.exe_s),
    .mem_wb_en_i      (bus.mem_wb_en),
    .mem_dest_i       (bus.mem_dest),
    .hazard_o         (hazard)
  );

  // SRAM access FSM; IDLE with a pending access already freezes so MEM cannot advance.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    err_d      = err_q;
    mem_freeze = 1'b0;
    req_pulse  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.mem_access) begin
          mem_freeze = 1'b1;
          state_d    = REQ;
        end else begin
          state_d    = IDLE;
        end
      end
      REQ: begin
        mem_freeze = 1'b1;
        req_pulse  = 1'b1;
        state_d    = WAIT;
      end
      WAIT: begin
        mem_freeze = 1'b1;
        if (bus.sram_ready) begin
          state_d    = DONE;
          wait_cnt_d = 4'd0;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d    = DONE;
          wait_cnt_d = 4'd0;
          err_d      = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d    = IDLE;
        wait_cnt_d = 4'd0;
      end
    endcase
  end

  // Output priority: memory freeze, then taken branch, then hazard stall.
  always_comb begin
    freeze_front = 1'b0;
    freeze_all   = 1'b0;
    flush_if_id  = 1'b0;
    flush_id_exe = 1'b0;
    sram_start   = 1'b0;
    if (rst) begin
      freeze_all = 1'b0;
    end else if (mem_freeze) begin
      freeze_all = 1'b1;
      sram_start = req_pulse;
    end else if (bus.exe_branch_taken) begin
      flush_if_id  = 1'b1;
      flush_id_exe = 1'b1;
    end else if (hazard) begin
      freeze_front = 1'b1;
      flush_id_exe = 1'b1;
    end else begin
      freeze_front = 1'b0;
    end
  end

  // Performance counters stick at all-ones instead of wrapping.
  always_comb begin
    stall_d  = stall_q;
    bubble_d = bubble_q;
    if (freeze_front || freeze_all) begin
      stall_d = sat_inc(stall_q);
    end else begin
      stall_d = stall_q;
    end
    if (flush_id_exe) begin
      bubble_d = sat_inc(bubble_q);
    end else begin
      bubble_d = bubble_q;
    end
  end

  // State, wait counter, sticky error and counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      wait_cnt_q <= 4'd0;
      err_q      <= 1'b0;
      stall_q    <= {CNT_W{1'b0}};
      bubble_q   <= {CNT_W{1'b0}};
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
      stall_q    <= stall_d;
      bubble_q   <= bubble_d;
    end
  end

  assign bus.freeze_front    = freeze_front;
  assign bus.freeze_all      = freeze_all;
  assign bus.flush_if_id     = flush_if_id;
  assign bus.flush_id_exe    = flush_id_exe;
  assign bus.sram_start      = sram_start;
  assign bus.mem_timeout_err = err_q;
  assign bus.stall_cycles    = stall_q;
  assign bus.bubble_count    = bubble_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench: dut0 (no forwarding, 3-bit counters) and dut1 (forwarding, 16-bit) share stimulus.
module tb_pipeline_hazard_ctrl;
  import pipe_ctrl_pkg::*;

  logic clk;
  logic rst;
  int   n_assert;
  int   n_fail;

  pipeline_hazard_ctrl_if #(.CNT_W(3))  b0 ();
  pipeline_hazard_ctrl_if #(.CNT_W(16)) b1 ();

  pipeline_hazard_ctrl #(.FWD_EN(1'b0), .MEM_TIMEOUT(15), .CNT_W(3)) dut0 (
    .clk (clk), .rst (rst), .bus (b0)
  );
  pipeline_hazard_ctrl #(.FWD_EN(1'b1), .MEM_TIMEOUT(15), .CNT_W(16)) dut1 (
    .clk (clk), .rst (rst), .bus (b1)
  );

  assign b1.id_src1          = b0.id_src1;
  assign b1.id_src2          = b0.id_src2;
  assign b1.id_two_src       = b0.id_two_src;
  assign b1.id_uses_status   = b0.id_uses_status;
  assign b1.exe_wb_en        = b0.exe_wb_en;
  assign b1.exe_dest         = b0.exe_dest;
  assign b1.exe_mem_r_en     = b0.exe_mem_r_en;
  assign b1.exe_s            = b0.exe_s;
  assign b1.mem_wb_en        = b0.mem_wb_en;
  assign b1.mem_dest         = b0.mem_dest;
  assign b1.mem_access       = b0.mem_access;
  assign b1.sram_ready       = b0.sram_ready;
  assign b1.exe_branch_taken = b0.exe_branch_taken;

  // {freeze_front, freeze_all, flush_if_id, flush_id_exe, sram_start, mem_timeout_err}
  logic [5:0] o0;
  logic [5:0] o1;
  assign o0 = {b0.freeze_front, b0.freeze_all, b0.flush_if_id, b0.flush_id_exe,
               b0.sram_start, b0.mem_timeout_err};
  assign o1 = {b1.freeze_front, b1.freeze_all, b1.flush_if_id, b1.flush_id_exe,
               b1.sram_start, b1.mem_timeout_err};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    b0.id_src1          = 4'd0;
    b0.id_src2          = 4'd0;
    b0.id_two_src       = 1'b0;
    b0.id_uses_status   = 1'b0;
    b0.exe_wb_en        = 1'b0;
    b0.exe_dest         = 4'd0;
    b0.exe_mem_r_en     = 1'b0;
    b0.exe_s            = 1'b0;
    b0.mem_wb_en        = 1'b0;
    b0.mem_dest         = 4'd0;
    b0.mem_access       = 1'b0;
    b0.sram_ready       = 1'b0;
    b0.exe_branch_taken = 1'b0;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst = 1'b1;
    clr();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Post-reset state
    next();
    #1;
    chk("reset_out0", {26'd0, o0}, 32'h0);
    chk("reset_out1", {26'd0, o1}, 32'h0);
    chk("reset_stall1", {16'd0, b1.stall_cycles}, 32'd0);
    chk("reset_bubble1", {16'd0, b1.bubble_count}, 32'd0);
    next();

    // RAW vs EXE on src1, no forwarding
    b0.exe_wb_en = 1'b1; b0.exe_dest = 4'd3; b0.id_src1 = 4'd3;
    #1;
    chk("raw_exe_nofwd", {26'd0, o0}, {26'd0, 6'b100100});
    chk("raw_exe_fwd_nonload", {26'd0, o1}, 32'h0);
    next();

    // src2 match ignored without id_two_src
    b0.id_src1 = 4'd1; b0.id_src2 = 4'd3; b0.id_two_src = 1'b0;
    #1;
    chk("src2_ignored", {26'd0, o0}, 32'h0);
    chk("bubble0_one", {29'd0, b0.bubble_count}, 32'd1);
    chk("stall0_one", {29'd0, b0.stall_cycles}, 32'd1);
    next();

    b0.id_two_src = 1'b1;
    #1;
    chk("src2_used", {26'd0, o0}, {26'd0, 6'b100100});
    next();

    // RAW vs MEM: stalls only without forwarding
    b0.exe_wb_en = 1'b0; b0.mem_wb_en = 1'b1; b0.mem_dest = 4'd7;
    b0.id_src1 = 4'd7; b0.id_two_src = 1'b0;
    #1;
    chk("raw_mem_nofwd", {26'd0, o0}, {26'd0, 6'b100100});
    chk("raw_mem_fwd", {26'd0, o1}, 32'h0);
    next();

    // Load-use on src2 with forwarding
    clr();
    b0.exe_wb_en = 1'b1; b0.exe_mem_r_en = 1'b1; b0.exe_dest = 4'd5;
    b0.id_src2 = 4'd5; b0.id_two_src = 1'b1;
    #1;
    chk("load_use_fwd", {26'd0, o1}, {26'd0, 6'b100100});
    chk("bubble1_before", {16'd0, b1.bubble_count}, 32'd0);
    next();

    clr();
    b0.id_src2 = 4'd5; b0.id_two_src = 1'b1;
    #1;
    chk("load_use_released", {26'd0, o1}, 32'h0);
    chk("bubble1_after", {16'd0, b1.bubble_count}, 32'd1);
    chk("stall1_after", {16'd0, b1.stall_cycles}, 32'd1);
    next();

    // Status hazard regardless of forwarding
    clr();
    b0.id_uses_status = 1'b1; b0.exe_s = 1'b1;
    #1;
    chk("status_nofwd", {26'd0, o0}, {26'd0, 6'b100100});
    chk("status_fwd", {26'd0, o1}, {26'd0, 6'b100100});
    next();

    // Branch beats a simultaneous load-use hazard
    clr();
    b0.exe_branch_taken = 1'b1; b0.exe_wb_en = 1'b1; b0.exe_mem_r_en = 1'b1;
    b0.exe_dest = 4'd5; b0.id_src1 = 4'd5;
    #1;
    chk("branch_vs_hazard1", {26'd0, o1}, {26'd0, 6'b001100});
    chk("branch_vs_hazard0", {26'd0, o0}, {26'd0, 6'b001100});
    next();

    clr();
    #1;
    chk("bubble1_branch", {16'd0, b1.bubble_count}, 32'd3);
    chk("stall1_branch", {16'd0, b1.stall_cycles}, 32'd2);
    chk("bubble0_branch", {29'd0, b0.bubble_count}, 32'd6);
    chk("stall0_branch", {29'd0, b0.stall_cycles}, 32'd5);
    next();

    // SRAM access completing after 3 WAIT cycles, branch arriving mid-WAIT
    b0.mem_access = 1'b1;
    #1;
    chk("mem_idle_freeze", {26'd0, o1}, {26'd0, 6'b010000});
    next();
    #1;
    chk("mem_req", {26'd0, o1}, {26'd0, 6'b010010});
    next();
    #1;
    chk("mem_wait1", {26'd0, o1}, {26'd0, 6'b010000});
    next();
    b0.exe_branch_taken = 1'b1;
    #1;
    chk("mem_wait2_branch", {26'd0, o1}, {26'd0, 6'b010000});
    next();
    b0.sram_ready = 1'b1;
    #1;
    chk("mem_wait3_ready", {26'd0, o1}, {26'd0, 6'b010000});
    next();
    b0.sram_ready = 1'b0;
    #1;
    chk("mem_done_branch", {26'd0, o1}, {26'd0, 6'b001100});
    chk("stall1_mem", {16'd0, b1.stall_cycles}, 32'd7);
    chk("bubble1_mem", {16'd0, b1.bubble_count}, 32'd3);
    next();
    clr();
    #1;
    chk("mem_back_idle", {26'd0, o1}, 32'h0);
    chk("bubble1_done", {16'd0, b1.bubble_count}, 32'd4);
    chk("stall0_saturated", {29'd0, b0.stall_cycles}, 32'd7);
    chk("bubble0_saturated", {29'd0, b0.bubble_count}, 32'd7);
    next();

    // SRAM never answers: forced release after 15 WAIT cycles
    b0.mem_access = 1'b1;
    #1;
    chk("tmo_idle", {26'd0, o1}, {26'd0, 6'b010000});
    next();
    #1;
    chk("tmo_req", {26'd0, o1}, {26'd0, 6'b010010});
    next();
    for (int i = 0; i < 15; i++) begin
      chk("tmo_wait", {26'd0, o1}, {26'd0, 6'b010000});
      next();
    end
    b0.mem_access = 1'b0;
    #1;
    chk("tmo_done1", {26'd0, o1}, {26'd0, 6'b000001});
    chk("tmo_done0", {26'd0, o0}, {26'd0, 6'b000001});
    next();
    #1;
    chk("tmo_sticky", {26'd0, o1}, {26'd0, 6'b000001});
    chk("stall1_tmo", {16'd0, b1.stall_cycles}, 32'd24);
    next();

    // Extra bubble on saturated counter
    b0.exe_wb_en = 1'b1; b0.exe_dest = 4'd2; b0.id_src1 = 4'd2;
    #1;
    chk("sat_hazard0", {26'd0, o0}, {26'd0, 6'b100101});
    chk("sat_nohazard1", {26'd0, o1}, {26'd0, 6'b000001});
    next();
    clr();
    #1;
    chk("bubble0_stays_sat", {29'd0, b0.bubble_count}, 32'd7);
    next();

    // Asynchronous reset in the middle of WAIT
    b0.mem_access = 1'b1;
    #1;
    chk("rst_idle", {26'd0, o1}, {26'd0, 6'b010001});
    next();
    #1;
    chk("rst_req", {26'd0, o1}, {26'd0, 6'b010011});
    next();
    b0.exe_branch_taken = 1'b1; b0.exe_wb_en = 1'b1; b0.exe_dest = 4'd4; b0.id_src1 = 4'd4;
    #1;
    chk("rst_wait", {26'd0, o1}, {26'd0, 6'b010001});
    #1;
    rst = 1'b1;
    #1;
    chk("rst_async_out1", {26'd0, o1}, 32'h0);
    chk("rst_async_out0", {26'd0, o0}, 32'h0);
    chk("rst_async_stall1", {16'd0, b1.stall_cycles}, 32'd0);
    chk("rst_async_bubble1", {16'd0, b1.bubble_count}, 32'd0);
    @(negedge clk);
    clr();
    rst = 1'b0;
    next();
    #1;
    chk("rst_no_reissue_a", {26'd0, o1}, 32'h0);
    next();
    #1;
    chk("rst_no_reissue_b", {26'd0, o1}, 32'h0);
    chk("rst_stall1_zero", {16'd0, b1.stall_cycles}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
